// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: per-cycle stall/bubble generation, CC-write gating,
// run-state machine (RUN/PAUSE/DRAIN/HALT) and saturating performance counters.
module pipe_ctrl #(
  parameter int CNT_W        = 32,
  parameter bit START_PAUSED = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [1:0]       m_stat,
  input  logic [1:0]       W_stat,
  input  logic             pause_req,
  input  logic             step_req,
  output logic             F_stall,
  output logic             D_stall,
  output logic             E_stall,
  output logic             M_stall,
  output logic             W_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             set_cc,
  output logic [1:0]       state,
  output logic             halted,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mp_cnt,
  output logic [CNT_W-1:0] ret_cnt
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_PAUSE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam logic [3:0] I_OPQ    = 4'd6;
  localparam logic [3:0] I_JXX    = 4'd7;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_POPQ   = 4'd11;
  localparam logic [3:0] R_NONE   = 4'd15;

  logic [1:0] state_reg, state_next;
  logic [1:0] fault_reg, fault_next;

  logic load_use, mispredict, ret_busy;
  logic m_exc, w_exc;
  logic freeze, active;

  assign load_use   = (E_icode == I_MRMOVQ || E_icode == I_POPQ) && E_dstM != R_NONE &&
                      (E_dstM == d_srcA || E_dstM == d_srcB);
  assign mispredict = (E_icode == I_JXX) && !e_Cnd;
  assign ret_busy   = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
  assign m_exc      = (m_stat != 2'd0);
  assign w_exc      = (W_stat != 2'd0);

  // A paused pipeline only moves forward on the cycle a step pulse arrives.
  assign freeze = (state_reg == ST_HALT) || (state_reg == ST_PAUSE && !step_req);
  assign active = (state_reg == ST_RUN) || (state_reg == ST_DRAIN) ||
                  (state_reg == ST_PAUSE && step_req);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= START_PAUSED ? ST_PAUSE : ST_RUN;
      fault_reg <= 2'd0;
    end else begin
      state_reg <= state_next;
      fault_reg <= fault_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    fault_next = fault_reg;
    if (state_reg != ST_HALT) begin
      if (w_exc) begin
        state_next = ST_HALT;
        fault_next = W_stat;
      end else begin
        case (state_reg)
          ST_RUN: begin
            if (m_exc)          state_next = ST_DRAIN;
            else if (pause_req) state_next = ST_PAUSE;
          end
          // The excepting instruction never reached W, so it was squashed.
          ST_DRAIN: state_next = pause_req ? ST_PAUSE : ST_RUN;
          ST_PAUSE: begin
            if (!pause_req)              state_next = ST_RUN;
            else if (step_req && m_exc)  state_next = ST_DRAIN;
          end
          default: state_next = state_reg;
        endcase
      end
    end
  end

  // Output logic
  always_comb begin
    F_stall  = load_use || ret_busy;
    D_stall  = load_use;
    E_stall  = 1'b0;
    M_stall  = 1'b0;
    W_stall  = w_exc;
    D_bubble = mispredict || (ret_busy && !load_use);
    E_bubble = mispredict || load_use;
    M_bubble = m_exc || w_exc;
    set_cc   = (E_icode == I_OPQ) && !m_exc && !w_exc;
    if (freeze) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      E_stall  = 1'b1;
      M_stall  = 1'b1;
      W_stall  = 1'b1;
      D_bubble = 1'b0;
      E_bubble = 1'b0;
      M_bubble = 1'b0;
      set_cc   = 1'b0;
    end
  end

  assign state      = state_reg;
  assign halted     = (state_reg == ST_HALT);
  assign fault_code = fault_reg;

  // Counter order: cycles, load-use, mispredict, ret
  logic [3:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_reg [4];

  assign cnt_inc = {ret_busy && !load_use, mispredict, load_use, 1'b1} & {4{active}};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_inc[gi] && cnt_reg[gi] != '1) begin
          cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign cyc_cnt = cnt_reg[0];
  assign lu_cnt  = cnt_reg[1];
  assign mp_cnt  = cnt_reg[2];
  assign ret_cnt = cnt_reg[3];

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: two instances (4-bit counters / RUN start and
// 8-bit counters / PAUSE start) driven by directed then random stimulus.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic       e_Cnd;
  logic [1:0] m_stat, W_stat;
  logic       pause_req, step_req;

  logic f_stall [2], d_stall [2], e_stall [2], m_stall [2], w_stall [2];
  logic d_bubble [2], e_bubble [2], m_bubble [2], set_cc [2], halted [2];
  logic [1:0] state [2], fault_code [2];
  logic [3:0][31:0] cnt_o [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int CW = (gi == 0) ? 4 : 8;
      logic [CW-1:0] c_cyc, c_lu, c_mp, c_ret;
      pipe_ctrl #(.CNT_W(CW), .START_PAUSED(gi == 1)) u_dut (
        .clk(clk), .reset(reset),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
        .pause_req(pause_req), .step_req(step_req),
        .F_stall(f_stall[gi]), .D_stall(d_stall[gi]), .E_stall(e_stall[gi]),
        .M_stall(m_stall[gi]), .W_stall(w_stall[gi]),
        .D_bubble(d_bubble[gi]), .E_bubble(e_bubble[gi]), .M_bubble(m_bubble[gi]),
        .set_cc(set_cc[gi]), .state(state[gi]), .halted(halted[gi]),
        .fault_code(fault_code[gi]),
        .cyc_cnt(c_cyc), .lu_cnt(c_lu), .mp_cnt(c_mp), .ret_cnt(c_ret)
      );
      assign cnt_o[gi] = {32'(c_ret), 32'(c_mp), 32'(c_lu), 32'(c_cyc)};
    end
  endgenerate

  typedef struct packed {
    logic [3:0] d_ic, sa, sb, e_ic, edm;
    logic       cnd;
    logic [3:0] m_ic;
    logic [1:0] ms, ws;
    logic       pr, st, rst;
  } stim_t;

  typedef struct packed {
    logic [4:0]       stl;   // F,D,E,M,W
    logic [2:0]       bub;   // D,E,M
    logic             scc;
    logic [1:0]       st;
    logic             hlt;
    logic [1:0]       fc;
    logic [3:0][31:0] cnt;   // ret,mp,lu,cyc
  } exp_t;

  typedef struct packed {
    exp_t e1;
    exp_t e0;
  } pair_t;

  pair_t sb_q [$];
  int n_vec = 0;
  int n_err = 0;
  int n_txn = 0;

  // Reference model: state 0 RUN, 1 PAUSE, 2 DRAIN, 3 HALT
  int          m_state [2];
  int          m_fault [2];
  int unsigned m_cnt [2][4];
  int unsigned cmax [2] = '{15, 255};

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = (k == 1) ? 1 : 0;
      m_fault[k] = 0;
      for (int i = 0; i < 4; i++) m_cnt[k][i] = 0;
    end
  endtask

  function automatic stim_t nop_stim();
    stim_t s;
    s = '0;
    s.d_ic = 4'd1; s.e_ic = 4'd1; s.m_ic = 4'd1;
    s.sa = 4'd15;  s.sb = 4'd15;  s.edm = 4'd15;
    s.cnd = 1'b1;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    bit lu, mp, rb, frz, act, ev[4];
    exp_t e [2];
    pair_t p;
    @(posedge clk);
    #1;
    reset = s.rst; D_icode = s.d_ic; d_srcA = s.sa; d_srcB = s.sb;
    E_icode = s.e_ic; E_dstM = s.edm; e_Cnd = s.cnd; M_icode = s.m_ic;
    m_stat = s.ms; W_stat = s.ws; pause_req = s.pr; step_req = s.st;

    lu = (s.e_ic == 5 || s.e_ic == 11) && s.edm != 15 && (s.edm == s.sa || s.edm == s.sb);
    mp = (s.e_ic == 7) && !s.cnd;
    rb = (s.d_ic == 9) || (s.e_ic == 9) || (s.m_ic == 9);
    ev[0] = 1'b1; ev[1] = lu; ev[2] = mp; ev[3] = rb && !lu;

    for (int k = 0; k < 2; k++) begin
      frz = (m_state[k] == 3) || (m_state[k] == 1 && !s.st);
      if (frz) begin
        e[k].stl = 5'b11111;
        e[k].bub = 3'b000;
        e[k].scc = 1'b0;
      end else begin
        e[k].stl = {lu || rb, lu, 1'b0, 1'b0, s.ws != 0};
        e[k].bub = {mp || (rb && !lu), mp || lu, s.ms != 0 || s.ws != 0};
        e[k].scc = (s.e_ic == 6) && s.ms == 0 && s.ws == 0;
      end
      e[k].st  = 2'(m_state[k]);
      e[k].hlt = (m_state[k] == 3);
      e[k].fc  = 2'(m_fault[k]);
      for (int i = 0; i < 4; i++) e[k].cnt[i] = m_cnt[k][i];

      if (s.rst) begin
        m_state[k] = (k == 1) ? 1 : 0;
        m_fault[k] = 0;
        for (int i = 0; i < 4; i++) m_cnt[k][i] = 0;
      end else begin
        act = (m_state[k] == 0) || (m_state[k] == 2) || (m_state[k] == 1 && s.st);
        for (int i = 0; i < 4; i++)
          if (act && ev[i] && m_cnt[k][i] < cmax[k]) m_cnt[k][i]++;
        if (m_state[k] == 3) begin
          m_state[k] = 3;
        end else if (s.ws != 0) begin
          m_state[k] = 3;
          m_fault[k] = int'(s.ws);
        end else if (m_state[k] == 0 && s.ms != 0) m_state[k] = 2;
        else if (m_state[k] == 0 && s.pr)         m_state[k] = 1;
        else if (m_state[k] == 2)                 m_state[k] = s.pr ? 1 : 0;
        else if (m_state[k] == 1 && !s.pr)        m_state[k] = 0;
        else if (m_state[k] == 1 && s.st && s.ms != 0) m_state[k] = 2;
      end
    end
    p.e0 = e[0];
    p.e1 = e[1];
    sb_q.push_back(p);
  endtask

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d txn %0d: got %0h, expected %0h", name, k, n_txn, act, exp);
    end
  endtask

  // Monitor: every cycle with a pending expectation is compared field by field.
  always @(negedge clk) begin
    pair_t p;
    exp_t  e;
    if (sb_q.size() != 0) begin
      p = sb_q.pop_front();
      for (int k = 0; k < 2; k++) begin
        e = (k == 0) ? p.e0 : p.e1;
        chk("stalls",  k, 32'({f_stall[k], d_stall[k], e_stall[k], m_stall[k], w_stall[k]}), 32'(e.stl));
        chk("bubbles", k, 32'({d_bubble[k], e_bubble[k], m_bubble[k]}), 32'(e.bub));
        chk("set_cc",  k, 32'(set_cc[k]), 32'(e.scc));
        chk("state",   k, 32'(state[k]), 32'(e.st));
        chk("halted",  k, 32'(halted[k]), 32'(e.hlt));
        chk("fault",   k, 32'(fault_code[k]), 32'(e.fc));
        chk("cyc_cnt", k, cnt_o[k][0], e.cnt[0]);
        chk("lu_cnt",  k, cnt_o[k][1], e.cnt[1]);
        chk("mp_cnt",  k, cnt_o[k][2], e.cnt[2]);
        chk("ret_cnt", k, cnt_o[k][3], e.cnt[3]);
      end
      $display("txn %0d: st=%0d/%0d stl=%b bub=%b cc=%b cyc=%0d lu=%0d mp=%0d ret=%0d",
               n_txn, state[0], state[1],
               {f_stall[0], d_stall[0], e_stall[0], m_stall[0], w_stall[0]},
               {d_bubble[0], e_bubble[0], m_bubble[0]}, set_cc[0],
               cnt_o[0][0], cnt_o[0][1], cnt_o[0][2], cnt_o[0][3]);
      n_txn++;
    end
  end

  initial begin
    stim_t s;
    logic  pr_lvl;
    reset = 1'b1; D_icode = 4'd1; d_srcA = 4'd15; d_srcB = 4'd15;
    E_icode = 4'd1; E_dstM = 4'd15; e_Cnd = 1'b1; M_icode = 4'd1;
    m_stat = 2'd0; W_stat = 2'd0; pause_req = 1'b0; step_req = 1'b0;
    @(posedge clk);
    model_reset();

    s = nop_stim(); s.rst = 1'b1; apply(s);
    s = nop_stim(); repeat (2) apply(s);
    // load-use
    s = nop_stim(); s.e_ic = 4'd5; s.edm = 4'd3; s.sa = 4'd3; apply(s);
    // mispredict
    s = nop_stim(); s.e_ic = 4'd7; s.cnd = 1'b0; s.d_ic = 4'd6; apply(s);
    // ret held, then ret with load-use
    s = nop_stim(); s.d_ic = 4'd9; repeat (3) apply(s);
    s.e_ic = 4'd11; s.edm = 4'd4; s.sa = 4'd4; apply(s);
    // mispredict together with ret
    s = nop_stim(); s.e_ic = 4'd7; s.cnd = 1'b0; s.m_ic = 4'd9; apply(s);
    // exception drain into halt, then frozen for 10 cycles
    s = nop_stim(); s.e_ic = 4'd6; s.ms = 2'd2; apply(s);
    s = nop_stim(); s.ws = 2'd2; apply(s);
    s = nop_stim(); s.e_ic = 4'd6; repeat (10) apply(s);
    // recovery from halt
    s.rst = 1'b1; apply(s);
    s = nop_stim(); repeat (2) apply(s);
    // squashed exception: drain returns to run
    s = nop_stim(); s.ms = 2'd3; apply(s);
    s = nop_stim(); repeat (2) apply(s);
    // pause with two steps
    s = nop_stim(); s.pr = 1'b1; s.e_ic = 4'd6; repeat (3) apply(s);
    s.st = 1'b1; apply(s);
    s.st = 1'b0; repeat (2) apply(s);
    s.st = 1'b1; apply(s);
    s.st = 1'b0; apply(s);
    s.pr = 1'b0; s.st = 1'b1; apply(s);
    // saturation of the 4-bit counters
    s = nop_stim(); s.e_ic = 4'd5; s.edm = 4'd2; s.sb = 4'd2; repeat (20) apply(s);

    pr_lvl = 1'b0;
    repeat (1500) begin
      s.d_ic = 4'($urandom_range(0, 11));
      s.e_ic = 4'($urandom_range(0, 11));
      s.m_ic = 4'($urandom_range(0, 11));
      s.sa   = ($urandom_range(0, 4) == 4) ? 4'd15 : 4'($urandom_range(0, 3));
      s.sb   = ($urandom_range(0, 4) == 4) ? 4'd15 : 4'($urandom_range(0, 3));
      s.edm  = ($urandom_range(0, 4) == 4) ? 4'd15 : 4'($urandom_range(0, 3));
      s.cnd  = 1'($urandom_range(0, 1));
      s.ms   = ($urandom_range(0, 29) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      s.ws   = ($urandom_range(0, 59) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      if ($urandom_range(0, 24) == 0) pr_lvl = ~pr_lvl;
      s.pr   = pr_lvl;
      s.st   = ($urandom_range(0, 2) == 0);
      s.rst  = (m_state[0] == 3 && $urandom_range(0, 7) == 0) || ($urandom_range(0, 299) == 0);
      apply(s);
    end

    s = nop_stim(); apply(s);
    repeat (3) @(negedge clk);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline control unit for the Y86-64 five-stage pipeline. Each cycle it generates the stall and bubble controls for the F/D/E/M/W pipeline registers from load-use, mispredict and ret hazards, and it gates condition-code updates on exceptions. A registered run-state machine handles exception drain, halt, and debug pause/single-step. It also keeps saturating performance counters. It sits beside fetch/decode/execute/memory/writeback and drives their stage-register enables.

Parameters:
CNT_W, 32, width of each performance counter
START_PAUSED, 0, 1 = leave reset in PAUSE instead of RUN

Ports:
clk  in  1  pipeline clock
reset  in  1  synchronous, active-high reset
D_icode  in  4  icode in D register
d_srcA  in  4  decode source A (15 = none)
d_srcB  in  4  decode source B (15 = none)
E_icode  in  4  icode in E register
E_dstM  in  4  memory destination in E (15 = none)
e_Cnd  in  1  branch/cmov condition from execute
M_icode  in  4  icode in M register
m_stat  in  2  memory-stage status (0 AOK, 1 HLT, 2 ADR, 3 INS)
W_stat  in  2  writeback-stage status
pause_req  in  1  level: freeze pipeline while high
step_req  in  1  pulse: advance one cycle while paused
F_stall, D_stall, E_stall, M_stall, W_stall  out  1 each  hold stage register
D_bubble, E_bubble, M_bubble  out  1 each  load nop into stage register
set_cc  out  1  enable CC write in execute
state  out  2  0 RUN, 1 PAUSE, 2 DRAIN, 3 HALT
halted  out  1  state==HALT
fault_code  out  2  W_stat latched on entry to HALT
cyc_cnt, lu_cnt, mp_cnt, ret_cnt  out  CNT_W each  perf counters

Behaviour:
- Hazard terms (combinational):
  - load_use = (E_icode==5 || E_icode==11) && E_dstM!=15 && (E_dstM==d_srcA || E_dstM==d_srcB).
  - mispredict = E_icode==7 && !e_Cnd.
  - ret_busy = 9 in any of D_icode/E_icode/M_icode.
- Normal controls:
  - F_stall = load_use || ret_busy.
  - D_stall = load_use.
  - D_bubble = mispredict || (ret_busy && !load_use).
  - E_bubble = mispredict || load_use.
  - M_bubble = m_stat!=0 || W_stat!=0.
  - W_stall = W_stat!=0.
  - E_stall = M_stall = 0.
- set_cc = E_icode==6 && m_stat==0 && W_stat==0. Forced 0 in HALT and in PAUSE when not stepping.
- Freeze controls: all five *_stall = 1, all bubbles = 0, set_cc = 0.
- Output selection by state:
  - HALT, and PAUSE without step_req: freeze controls.
  - PAUSE with step_req, RUN, DRAIN: normal controls.
  - Stall/bubble outputs are combinational, same-cycle. state, fault_code and the counters are registered.
- Transitions, evaluated each clk edge, priority top-down:
  - reset=1: state <= START_PAUSED ? PAUSE : RUN; fault_code <= 0; all counters <= 0. Reset mid-drain or in HALT fully recovers.
  - HALT: hold. Exit only via reset.
  - Any other state, W_stat!=0: state <= HALT; fault_code <= W_stat.
  - RUN, m_stat!=0: DRAIN.
  - RUN, pause_req: PAUSE.
  - DRAIN: after 1 cycle, HALT if W_stat!=0. Otherwise (exception was squashed) RUN, or PAUSE if pause_req.
  - PAUSE, !pause_req: RUN. A step_req in the same cycle as release is treated as an ordinary RUN cycle.
  - PAUSE, step_req with m_stat!=0: DRAIN.
  - Otherwise hold.
- Counters: saturate at all-ones with no wrap. They advance only on "active" cycles: RUN, DRAIN, or PAUSE with step_req.
  - cyc_cnt: +1 per active cycle.
  - lu_cnt: +1 per active cycle with load_use.
  - mp_cnt: +1 per active cycle with mispredict.
  - ret_cnt: +1 per active cycle with ret_busy && !load_use.
- Simultaneous mispredict and ret_busy: both bubbles asserted; counted in mp_cnt and ret_cnt.

Test Plan:
- Load-use: E_icode=5, E_dstM=3, d_srcA=3 in RUN -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; lu_cnt 0->1 next edge.
- Mispredict: E_icode=7, e_Cnd=0, D_icode=6 -> D_bubble=1, E_bubble=1, F_stall=0; mp_cnt=1.
- Ret combined with load-use: D_icode=9 held 3 cycles -> F_stall=1, D_bubble=1 each cycle, ret_cnt=3. Add E_icode=11, E_dstM=4, d_srcA=4 -> D_stall=1, D_bubble=0, E_bubble=1.
- Exception drain: m_stat=2 in RUN -> M_bubble=1, set_cc=0, state=DRAIN. Next cycle W_stat=2 -> W_stall=1, state=HALT, fault_code=2, all stalls 1. Counters freeze; cyc_cnt stays constant for 10 cycles.
- Pause/step: pause_req=1 -> state=PAUSE, all stalls=1, cyc_cnt frozen. Two step_req pulses -> exactly 2 normal-control cycles, cyc_cnt +2. pause_req=0 -> RUN.
- Saturation/reset: CNT_W=4, 20 active cycles -> cyc_cnt=15. reset=1 while in HALT -> next edge state=RUN, counters 0, fault_code 0. START_PAUSED=1 -> state=PAUSE after reset.
